// File: rtl/wash_pkg.sv
// Shared constants for the washing-machine controller: top-level state codes,
// program indices, per-program phase masks and the configuration FSM states.
package wash_pkg;

    // Top-level machine state codes
    localparam logic [2:0] shutDownST = 3'd0;
    localparam logic [2:0] beginST    = 3'd1;
    localparam logic [2:0] setST      = 3'd2;
    localparam logic [2:0] runST      = 3'd3;
    localparam logic [2:0] errorST    = 3'd4;
    localparam logic [2:0] sleepST    = 3'd5;

    // Program indices (W = wash, R = rinse, D = dry, USE = custom)
    localparam logic [2:0] set_WRD_ST = 3'd0;
    localparam logic [2:0] set_W_ST   = 3'd1;
    localparam logic [2:0] set_WR_ST  = 3'd2;
    localparam logic [2:0] set_R_ST   = 3'd3;
    localparam logic [2:0] set_RD_ST  = 3'd4;
    localparam logic [2:0] set_D_ST   = 3'd5;
    localparam logic [2:0] set_USE_ST = 3'd6;

    // Phase masks, bit order {wash, rinse, dry}
    localparam logic [2:0] MASK_WRD = 3'b111;
    localparam logic [2:0] MASK_W   = 3'b100;
    localparam logic [2:0] MASK_WR  = 3'b110;
    localparam logic [2:0] MASK_R   = 3'b010;
    localparam logic [2:0] MASK_RD  = 3'b011;
    localparam logic [2:0] MASK_D   = 3'b001;
    localparam logic [2:0] MASK_USE = 3'b111;

    // Configuration FSM: selecting, offering to the run controller, handed off
    typedef enum logic [1:0] {
        CFG_SEL  = 2'd0,
        CFG_HOLD = 2'd1,
        CFG_LOCK = 2'd2
    } cfg_fsm_e;

endpackage

// File: rtl/wash_prog_table.sv
// Combinational program-index to phase-mask lookup, shared with the display path.
module wash_prog_table
    import wash_pkg::*;
(
    input  logic [2:0] prog,
    output logic [2:0] phase_mask
);

    // Decode the program index into its {wash, rinse, dry} enables
    always_comb begin
        // NOTE: a default before the case means no path leaves phase_mask unassigned, so no latch.
        phase_mask = 3'b000;
        case (prog)
            set_WRD_ST: phase_mask = MASK_WRD;
            set_W_ST:   phase_mask = MASK_W;
            set_WR_ST:  phase_mask = MASK_WR;
            set_R_ST:   phase_mask = MASK_R;
            set_RD_ST:  phase_mask = MASK_RD;
            set_D_ST:   phase_mask = MASK_D;
            set_USE_ST: phase_mask = MASK_USE;
            default:    phase_mask = 3'b000;
        endcase
    end

endmodule

// File: rtl/wash_prog_cfg.sv
// Program-configuration block: program selection / custom editing while the
// machine is in setST, registered phase times and total duration, and a
// valid/ready hand-off of the confirmed program.
// Optional feature macro: WASH_RINSE_CNT_EN (adjustable rinse count via rinseBtn).
module wash_prog_cfg
    import wash_pkg::*;
#(
    parameter int TIME_W    = 3,
    parameter int MIN_TIME  = 1,
    parameter int MAX_TIME  = 7,
    parameter int DEF_TIME  = 3,
    parameter int RINSE_T   = 4,
    parameter int DRY_T     = 5,
    parameter int RINSE_MAX = 3
) (
    input  logic              cp,
    input  logic              rst,
    input  logic [2:0]        state,
    input  logic              click,
    input  logic              waterBtn,
    input  logic              rinseBtn,
    input  logic              confirm,
    output logic [2:0]        prog,
    output logic [2:0]        phase_mask,
    output logic [TIME_W-1:0] wash_time,
    output logic [TIME_W-1:0] rinse_time,
    output logic [TIME_W-1:0] dry_time,
    output logic [1:0]        rinse_cnt,
    output logic [TIME_W+2:0] total_time,
    output logic              sched_valid,
    input  logic              sched_ready
);

    localparam int                TOT_W   = TIME_W + 3;
    localparam logic [TIME_W-1:0] MIN_T   = TIME_W'(MIN_TIME);
    localparam logic [TIME_W-1:0] MAX_T   = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] DEF_T   = TIME_W'(DEF_TIME);
    localparam logic [TIME_W-1:0] RINSE_C = TIME_W'(RINSE_T);
    localparam logic [TIME_W-1:0] DRY_C   = TIME_W'(DRY_T);
    localparam logic [TOT_W-1:0]  TOT_RST = TOT_W'(DEF_TIME + RINSE_T + DRY_T);

    cfg_fsm_e          fsm;
    logic [TIME_W-1:0] wash_set;
    logic [TIME_W-1:0] wash_inc;
    logic [TIME_W-1:0] wash_nxt;
    logic [2:0]        prog_nxt;
    logic [1:0]        rcnt_nxt;
    logic [2:0]        mask_nxt;
    logic [TIME_W-1:0] wash_t_nxt;
    logic [TIME_W-1:0] rinse_t_nxt;
    logic [TIME_W-1:0] dry_t_nxt;
    logic [TOT_W-1:0]  total_nxt;
    logic              edit;
    logic              rinse_hit;
    logic              restart;

    // beginST behaves exactly like rst and outranks every button and the handshake
    assign restart  = rst || (state == beginST);
    // Edit buttons only matter while selecting in setST and not confirming this cycle
    assign edit     = (fsm == CFG_SEL) && (state == setST) && !confirm;
    assign wash_inc = wash_set + TIME_W'(1);

`ifdef WASH_RINSE_CNT_EN
    localparam logic [1:0] RMAX = 2'(RINSE_MAX);
    // rinseBtn only claims priority when it can act, i.e. on the custom program
    assign rinse_hit = rinseBtn && (prog == set_USE_ST);
`else
    logic unused_rinse;
    assign unused_rinse = rinseBtn ^ (RINSE_MAX == 0);
    assign rinse_hit    = 1'b0;
`endif

    // Next program, wash setting and rinse count from the highest-priority button
    always_comb begin
        prog_nxt = prog;
        wash_nxt = wash_set;
        rcnt_nxt = rinse_cnt;
        if (edit) begin
            if (waterBtn) begin
                prog_nxt = set_USE_ST;
                if (wash_set >= MAX_T)
                    wash_nxt = MAX_T;
                else if (wash_inc < MIN_T)
                    wash_nxt = MIN_T;
                else
                    wash_nxt = wash_inc;
            end else if (rinse_hit) begin
`ifdef WASH_RINSE_CNT_EN
                rcnt_nxt = (rinse_cnt >= RMAX) ? 2'd1 : rinse_cnt + 2'd1;
`endif
            end else if (click) begin
                if (prog == set_USE_ST) begin
                    // Leaving the custom program restores its defaults
                    prog_nxt = set_WRD_ST;
                    wash_nxt = DEF_T;
                    rcnt_nxt = 2'd1;
                end else begin
                    prog_nxt = prog + 3'd1;
                end
            end
        end
    end

    wash_prog_table u_table (
        .prog       (prog_nxt),
        .phase_mask (mask_nxt)
    );

    // Phase times and total duration for the next program, computed at full width
    always_comb begin
        wash_t_nxt  = mask_nxt[2] ? wash_nxt : '0;
        rinse_t_nxt = mask_nxt[1] ? RINSE_C  : '0;
        dry_t_nxt   = mask_nxt[0] ? DRY_C    : '0;
        total_nxt   = TOT_W'(wash_t_nxt) + TOT_W'(rinse_t_nxt) * TOT_W'(rcnt_nxt)
                    + TOT_W'(dry_t_nxt);
    end

    // FSM, handshake and registered outputs
    always_ff @(posedge cp) begin
        if (restart) begin
            fsm         <= CFG_SEL;
            sched_valid <= 1'b0;
            prog        <= set_WRD_ST;
            wash_set    <= DEF_T;
            rinse_cnt   <= 2'd1;
            phase_mask  <= MASK_WRD;
            wash_time   <= DEF_T;
            rinse_time  <= RINSE_C;
            dry_time    <= DRY_C;
            total_time  <= TOT_RST;
        end else begin
            // NOTE: non-blocking assignments make every register here see pre-edge values.
            case (fsm)
                CFG_SEL: begin
                    if ((state == setST) && confirm) begin
                        fsm         <= CFG_HOLD;
                        sched_valid <= 1'b1;
                    end
                end
                CFG_HOLD: begin
                    if (sched_valid && sched_ready) begin
                        fsm         <= CFG_LOCK;
                        sched_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm <= fsm;
                end
            endcase
            // Outside editing the next values equal the current ones, so outputs stay frozen
            prog       <= prog_nxt;
            wash_set   <= wash_nxt;
            rinse_cnt  <= rcnt_nxt;
            phase_mask <= mask_nxt;
            wash_time  <= wash_t_nxt;
            rinse_time <= rinse_t_nxt;
            dry_time   <= dry_t_nxt;
            total_time <= total_nxt;
        end
    end

endmodule

// File: doc/wash_prog_cfg.md
# wash_prog_cfg

Parametrised program-configuration block for the washing-machine controller. While the top-level machine is in its set state, it lets the user step through the fixed wash programs or build a custom one with adjustable wash time and rinse count. It publishes per-phase times, a phase-enable mask and a total duration. On confirm, it hands the chosen program to the run controller through a valid/ready handshake.

## Interface
- `TIME_W`, 3: width of each phase time field.
- `MIN_TIME`, 1: lower bound of the custom wash time.
- `MAX_TIME`, 7: upper bound of the custom wash time; must be ≤ 2^TIME_W−1.
- `DEF_TIME`, 3: default wash time; also the reset value.
- `RINSE_T`, 4: fixed rinse time per rinse pass.
- `DRY_T`, 5: fixed dry time.
- `RINSE_MAX`, 3: maximum rinse passes.

Ports:
- `cp` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `state` in 3: top-level machine state. beginST=1, setST=2; all other codes count as "other".
- `click` in 1: one-cycle pulse, next program.
- `waterBtn` in 1: one-cycle pulse, custom mode plus wash-time increment.
- `rinseBtn` in 1: one-cycle pulse, rinse-count increment.
- `confirm` in 1: one-cycle pulse, accept the current program.
- `prog` out 3: current program index. 0=WRD, 1=W, 2=WR, 3=R, 4=RD, 5=D, 6=USE.
- `phase_mask` out 3: {wash, rinse, dry} enables.
- `wash_time`, `rinse_time`, `dry_time` out TIME_W each: phase times; 0 when the phase is disabled.
- `rinse_cnt` out 2: number of rinse passes.
- `total_time` out TIME_W+3: wash_time + rinse_time·rinse_cnt + dry_time.
- `sched_valid` out 1: program offered to the run controller.
- `sched_ready` in 1: run controller accepts.

## Operation
- The FSM has three states:
  - SEL: user selecting or editing.
  - HOLD: sched_valid=1, waiting for ready.
  - LOCK: handed off, inputs ignored.
- Reset: FSM=SEL, prog=0, wash setting=DEF_TIME, rinse_cnt=1, sched_valid=0.
- Reset-derived outputs: phase_mask=111, wash_time=DEF_TIME, rinse_time=RINSE_T, dry_time=DRY_T, total_time=DEF_TIME+RINSE_T+DRY_T.
- `state`==beginST, from any FSM state: same effect as reset. This has priority over every button and over the handshake, and it drops sched_valid without transfer.
- In SEL, buttons act only when `state`==setST.
- Button priority: confirm > waterBtn > rinseBtn > click.
- click: prog = (prog==6) ? 0 : prog+1. Leaving USE restores wash=DEF_TIME and rinse_cnt=1.
- waterBtn: prog=6; wash = min(wash+1, MAX_TIME), saturating rather than wrapping.
  - First press from a non-USE program starts from the current wash setting. Because click restores DEF_TIME, the first press from a fixed program gives DEF_TIME+1.
- rinseBtn: effective only when prog=6. rinse_cnt = (rinse_cnt==RINSE_MAX) ? 1 : rinse_cnt+1.
- confirm: SEL→HOLD; sched_valid=1.
- HOLD: when sched_valid && sched_ready, go to LOCK and set sched_valid=0 on the same edge. Outputs stay frozen in HOLD and LOCK.
- LOCK exits only via beginST or rst.
- Phase mask by program: WRD 111, W 100, WR 110, R 010, RD 011, D 001, USE 111.
- Time outputs: wash time equals the wash setting when enabled, and rinse/dry times equal the constants when enabled; disabled phases output 0.
- total_time is computed at full width TIME_W+3 with no overflow for legal parameters.

## Timing
- All outputs are registered; a button takes effect on the next `cp` edge, giving 1-cycle latency.
- total_time and the time fields update on the same edge as prog.
- sched_valid rises on the edge after confirm. Transfer happens on any edge where valid and ready are both high; ready with valid low has no effect.
- Button pulses arriving while `state`≠setST are discarded, not queued.
- rst mid-HOLD clears valid on the next edge with no transfer.

## Configuration
- `WASH_RINSE_CNT_EN` defined: rinseBtn and a variable rinse_cnt in the range 1..RINSE_MAX are supported.
- Not defined: rinseBtn is ignored, rinse_cnt is tied to 1, and total_time = wash_time + rinse_time + dry_time. The port list is unchanged.

## Structure
- Shared package `wash_pkg` holds:
  - the top-level state codes (shutDownST..sleepST);
  - the program index constants (set_WRD_ST..set_USE_ST);
  - the 3-bit phase-mask constants per program.
- One sub-module, `wash_prog_table`: combinational prog → phase_mask lookup, reused by the display path.

## Test plan
- Reset, then 7 clicks in setST: prog steps 1..6 and then 0. At prog=1, total_time=3, and after the final click prog=0 with total_time=12.
- From prog=2, 5 waterBtn pulses with MAX_TIME=7: prog=6, wash_time goes 4,5,6,7,7, showing saturation.
- With `WASH_RINSE_CNT_EN`, prog=6 and wash=3: rinseBtn ×3 gives rinse_cnt 2,3,1, and total_time is 16 after the first press. Without the macro, rinse_cnt stays 1.
- click and waterBtn asserted together at prog=0: prog=6 and wash=4.
- Handshake: confirm with ready=0 for 4 cycles keeps valid high and outputs frozen. Raising ready gives one transfer, after which valid=0, the FSM is in LOCK, and clicks are ignored.
- beginST during HOLD: valid drops with no transfer, prog=0, wash=3.
